btn_ctrl: RTL



---
 rtl/btn_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/btn_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// btn_ctrl - per-button synchroniser and debouncer with sticky W1C press flags
// Revision: 1.0
//------------------------------------------------------------------------------
module btn_ctrl #(
  parameter int BTN_NUM      = 4,
  parameter int DEBOUNCE_CNT = 100000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [BTN_NUM-1:0] btn,
  input  logic [31:0]        btn_clr,
  output logic [31:0]        btn_state,
  output logic [31:0]        btn_event,
  output logic               btn_irq
);

  localparam int                 CNT_W    = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [BTN_NUM-1:0] REL_LVL  = {BTN_NUM{ACTIVE_LOW}};

  logic [BTN_NUM-1:0] sync1_q;
  logic [BTN_NUM-1:0] sync2_q;
  logic [BTN_NUM-1:0] stable_q;
  logic [BTN_NUM-1:0] stable_d;
  logic [BTN_NUM-1:0] event_q;
  logic [BTN_NUM-1:0] event_d;
  logic [BTN_NUM-1:0] rise_d;
  logic [BTN_NUM-1:0] pressed;
  logic               irq_q;
  logic               irq_d;

  // Sync stages reset to the released pin level so no phantom press follows reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = sync2_q ^ REL_LVL;

  for (genvar i = 0; i < BTN_NUM; i++) begin : g_bit
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             bit_stable_d;
    logic             bit_rise_d;

    always_comb begin
      cnt_d        = cnt_q;
      bit_stable_d = stable_q[i];
      bit_rise_d   = 1'b0;
      if (pressed[i] == stable_q[i]) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d        = '0;
        bit_stable_d = pressed[i];
        bit_rise_d   = pressed[i];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign stable_d[i] = bit_stable_d;
    assign rise_d[i]   = bit_rise_d;
  end

  // A qualifying press on the same edge as a clear keeps the flag set.
  always_comb begin
    event_d = (event_q & ~btn_clr[BTN_NUM-1:0]) | rise_d;
    irq_d   = |event_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable_q <= '0;
      event_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      stable_q <= stable_d;
      event_q  <= event_d;
      irq_q    <= irq_d;
    end
  end

  assign btn_irq = irq_q;

  if (BTN_NUM < 32) begin : g_pad
    logic unused_clr;
    assign unused_clr = |btn_clr[31:BTN_NUM];
    assign btn_state  = {{(32 - BTN_NUM){1'b0}}, stable_q};
    assign btn_event  = {{(32 - BTN_NUM){1'b0}}, event_q};
  end else begin : g_full
    assign btn_state = stable_q;
    assign btn_event = event_q;
  end

endmodule
`default_nettype wire
